// File: rtl/data_mem_responder_pkg.sv
// Shared constants, decode types and register-image helpers for the
// data-memory responder.
package data_mem_responder_pkg;

  // MMIO register byte offsets inside the 256-byte page
  localparam logic [7:0] MMIO_CYCLE   = 8'h00;
  localparam logic [7:0] MMIO_CONSOLE = 8'h04;
  localparam logic [7:0] MMIO_STATUS  = 8'h08;

  // CONSOLE read image bit positions
  localparam int CON_EMPTY_BIT = 0;
  localparam int CON_FULL_BIT  = 1;
  localparam int CON_COUNT_LSB = 4;

  // STATUS read image bit positions
  localparam int STAT_ERR_BIT  = 0;
  localparam int STAT_DROP_LSB = 8;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    RGN_UNMAPPED,
    RGN_RAM,
    RGN_MMIO
  } region_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_CYCLE,
    REG_CONSOLE,
    REG_STATUS
  } mmio_reg_e;

  typedef struct packed {
    region_e   rgn;
    mmio_reg_e mreg;
  } decode_t;

  // Word offset within the MMIO page -> register select
  function automatic mmio_reg_e mmio_reg(input logic [5:0] word_off);
    mmio_reg_e r;
    case (word_off)
      MMIO_CYCLE[7:2]:   r = REG_CYCLE;
      MMIO_CONSOLE[7:2]: r = REG_CONSOLE;
      MMIO_STATUS[7:2]:  r = REG_STATUS;
      default:           r = REG_NONE;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] console_word(input logic [3:0] cnt,
                                               input logic full,
                                               input logic empty);
    logic [31:0] w;
    w = '0;
    w[CON_COUNT_LSB +: 4] = cnt;
    w[CON_FULL_BIT]       = full;
    w[CON_EMPTY_BIT]      = empty;
    return w;
  endfunction

  function automatic logic [31:0] status_word(input logic err,
                                              input logic [7:0] drop);
    logic [31:0] w;
    w = '0;
    w[STAT_DROP_LSB +: 8] = drop;
    w[STAT_ERR_BIT]       = err;
    return w;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-memory bus plus the console drain handshake.
interface data_mem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;

  // Core side plus console sink
  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout, con_ready,
    input  mem_din, con_valid, con_data
  );

  // Responder side
  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout, con_ready,
    output mem_din, con_valid, con_data
  );
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO for the console. DEPTH must be a power of two >= 2 so the
// pointers wrap naturally. A push into a full FIFO is still taken when a
// pop happens in the same cycle.
module byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage; stale entries are masked by the empty flag, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the MIPS core data-memory port: word RAM, plus an MMIO page
// holding a free-running cycle counter, a console byte FIFO and sticky
// error/drop status. Reads are combinational, writes land at the clock edge.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  decode_t               dec;

  logic [31:0] cycle_q;
  logic        err_q;
  logic [7:0]  drop_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [3:0]       count4;
  logic [7:0]       fifo_head;

  logic        ram_we;
  logic        mmio_we;
  logic        cyc_we;
  logic        con_push;
  logic        stat_clr;
  logic        unmapped;
  logic        con_pop;
  logic        drop;
  logic [31:0] rdata;
  logic        unused_addr_lsbs;

  // Byte-lane bits are ignored: everything is word-addressed
  assign unused_addr_lsbs = ^bus.mem_addr[1:0];
  assign ram_idx          = bus.mem_addr[ADDR_WIDTH+1:2];

  // Address decode; RAM takes priority if the regions ever overlap
  always_comb begin
    dec.rgn  = RGN_UNMAPPED;
    dec.mreg = REG_NONE;
    if (bus.mem_addr[31:ADDR_WIDTH+2] == '0) begin
      dec.rgn = RGN_RAM;
    end else if (bus.mem_addr[31:8] == MMIO_BASE[31:8]) begin
      dec.rgn  = RGN_MMIO;
      dec.mreg = mmio_reg(bus.mem_addr[7:2]);
    end
  end

  // RAM writes are not gated by reset; MMIO side effects are
  assign ram_we   = bus.mem_wen && (dec.rgn == RGN_RAM);
  assign mmio_we  = bus.mem_wen && (dec.rgn == RGN_MMIO) && !rst;
  assign cyc_we   = mmio_we && (dec.mreg == REG_CYCLE);
  assign con_push = mmio_we && (dec.mreg == REG_CONSOLE);
  assign stat_clr = mmio_we && (dec.mreg == REG_STATUS);
  assign unmapped = (bus.mem_ren || bus.mem_wen) && (dec.rgn == RGN_UNMAPPED);

  assign con_pop  = !fifo_empty && bus.con_ready;
  // Mirrors the FIFO's acceptance rule: full and nothing leaving
  assign drop     = con_push && fifo_full && !con_pop;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.mem_dout;
  end

  // Cycle counter; a write zeroes it in the write cycle, so the next cycle
  // already reads 1
  always_ff @(posedge clk) begin
    if (rst)         cycle_q <= '0;
    else if (cyc_we) cycle_q <= 32'd1;
    else             cycle_q <= cycle_q + 32'd1;
  end

  // Sticky error and saturating drop counter; a STATUS write clears both
  // and beats any same-cycle set/increment
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (stat_clr)      err_q <= 1'b0;
      else if (unmapped) err_q <= 1'b1;

      if (stat_clr)                        drop_q <= '0;
      else if (drop && drop_q != DROP_MAX) drop_q <= drop_q + 8'd1;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (con_push),
    .push_data (bus.mem_dout[7:0]),
    .pop       (con_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign count4 = 4'(fifo_count);

  // Combinational read mux; pre-write values are visible in a write cycle
  always_comb begin
    rdata = '0;
    case (dec.rgn)
      RGN_RAM:  rdata = ram[ram_idx];
      RGN_MMIO: begin
        case (dec.mreg)
          REG_CYCLE:   rdata = cycle_q;
          REG_CONSOLE: rdata = console_word(count4, fifo_full, fifo_empty);
          REG_STATUS:  rdata = status_word(err_q, drop_q);
          default:     rdata = '0;
        endcase
      end
      default:  rdata = '0;
    endcase
  end

  assign bus.mem_din   = bus.mem_ren ? rdata : '0;
  assign bus.con_valid = !fifo_empty;
  assign bus.con_data  = fifo_head;

endmodule
